// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module   : register_file
// Purpose  : Architectural register file with rename status. Commits from the
//            reorder buffer write x1..x31 and release rename tags; the issue
//            unit renames rd onto a ROB entry and reads rs1/rs2 either as a
//            value or as a producer ROB tag. x0 is hard-wired to zero.
// Ports    : clk_in, rst_in (async, active-high), rdy_in (global enable),
//            clr_in (flush)
//            issue_ready / issue_rd_id / issue_rob_index       : rename
//            iu_rs1_id / iu_rs2_id                             : operand ids
//            rf_to_iu_rs{1,2}_busy / _depend, rf_to_iu_val{1,2}: operand read
//            rob_to_rf_ready / _reg_id / _reg_val / _rob_index : commit
// Revision : 1.0 - initial release
// ============================================================================
module register_file #(
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clr_in,
  input  logic                 issue_ready,
  input  logic [4:0]           issue_rd_id,
  input  logic [ROB_WIDTH-1:0] issue_rob_index,
  input  logic [4:0]           iu_rs1_id,
  input  logic [4:0]           iu_rs2_id,
  output logic                 rf_to_iu_rs1_busy,
  output logic [ROB_WIDTH-1:0] rf_to_iu_rs1_depend,
  output logic [31:0]          rf_to_iu_val1,
  output logic                 rf_to_iu_rs2_busy,
  output logic [ROB_WIDTH-1:0] rf_to_iu_rs2_depend,
  output logic [31:0]          rf_to_iu_val2,
  input  logic                 rob_to_rf_ready,
  input  logic [4:0]           rob_to_rf_reg_id,
  input  logic [31:0]          rob_to_rf_reg_val,
  input  logic [ROB_WIDTH-1:0] rob_to_rf_rob_index
);

  localparam int c_NUM_REGS = 32;

  typedef struct packed {
    logic                 busy;
    logic [ROB_WIDTH-1:0] depend;
    logic [31:0]          val;
  } rd_result_t;

  logic [31:0]          r_regs [c_NUM_REGS];
  logic [c_NUM_REGS-1:0] r_busy;
  logic [ROB_WIDTH-1:0] r_tag  [c_NUM_REGS];

  rd_result_t w_rs1;
  rd_result_t w_rs2;

  logic w_commit;
  logic w_commit_releases;
  logic w_issue;

  // Operand read. A commit in flight for the exact producer the operand waits
  // on is forwarded so the issue unit does not miss the value for one cycle.
  // A same-cycle issue is deliberately not visible here: the issuing
  // instruction reads its sources before its own rd is renamed.
  function automatic rd_result_t f_read(input logic [4:0] id);
    rd_result_t res;
    res = '0;
    if (id != 5'd0) begin
      if (!r_busy[id]) begin
        res.val = r_regs[id];
      end else if (rob_to_rf_ready && (rob_to_rf_reg_id == id) &&
                   (rob_to_rf_rob_index == r_tag[id])) begin
        res.val = rob_to_rf_reg_val;
      end else begin
        res.busy   = 1'b1;
        res.depend = r_tag[id];
        res.val    = r_regs[id];
      end
    end
    return res;
  endfunction

  assign w_rs1 = f_read(iu_rs1_id);
  assign w_rs2 = f_read(iu_rs2_id);

  assign rf_to_iu_rs1_busy   = w_rs1.busy;
  assign rf_to_iu_rs1_depend = w_rs1.depend;
  assign rf_to_iu_val1       = w_rs1.val;
  assign rf_to_iu_rs2_busy   = w_rs2.busy;
  assign rf_to_iu_rs2_depend = w_rs2.depend;
  assign rf_to_iu_val2       = w_rs2.val;

  assign w_commit = rob_to_rf_ready && (rob_to_rf_reg_id != 5'd0);
  // Only the youngest writer (the one whose tag is recorded) may clear busy.
  assign w_commit_releases = w_commit && r_busy[rob_to_rf_reg_id] &&
                             (r_tag[rob_to_rf_reg_id] == rob_to_rf_rob_index);
  assign w_issue  = issue_ready && (issue_rd_id != 5'd0) && !clr_in;

  // Update order inside one edge: commit, then issue (wins on same rd), then
  // flush (wipes all rename state but keeps the committed value).
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_busy <= '0;
      for (int i = 0; i < c_NUM_REGS; i++) begin
        r_regs[i] <= '0;
        r_tag[i]  <= '0;
      end
    end else if (rdy_in) begin
      if (w_commit) begin
        r_regs[rob_to_rf_reg_id] <= rob_to_rf_reg_val;
      end
      if (w_commit_releases) begin
        r_busy[rob_to_rf_reg_id] <= 1'b0;
        r_tag[rob_to_rf_reg_id]  <= '0;
      end
      if (w_issue) begin
        r_busy[issue_rd_id] <= 1'b1;
        r_tag[issue_rd_id]  <= issue_rob_index;
      end
      if (clr_in) begin
        r_busy <= '0;
        for (int i = 0; i < c_NUM_REGS; i++) begin
          r_tag[i] <= '0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_register_file
// Purpose  : Directed self-checking bench for register_file.
// Revision : 1.0 - initial release
// ============================================================================
module tb_register_file;

  localparam int ROB_WIDTH = 4;

  logic                 clk_in = 1'b0;
  logic                 rst_in;
  logic                 rdy_in;
  logic                 clr_in;
  logic                 issue_ready;
  logic [4:0]           issue_rd_id;
  logic [ROB_WIDTH-1:0] issue_rob_index;
  logic [4:0]           iu_rs1_id;
  logic [4:0]           iu_rs2_id;
  logic                 rf_to_iu_rs1_busy;
  logic [ROB_WIDTH-1:0] rf_to_iu_rs1_depend;
  logic [31:0]          rf_to_iu_val1;
  logic                 rf_to_iu_rs2_busy;
  logic [ROB_WIDTH-1:0] rf_to_iu_rs2_depend;
  logic [31:0]          rf_to_iu_val2;
  logic                 rob_to_rf_ready;
  logic [4:0]           rob_to_rf_reg_id;
  logic [31:0]          rob_to_rf_reg_val;
  logic [ROB_WIDTH-1:0] rob_to_rf_rob_index;

  int checks = 0;
  int errors = 0;

  register_file #(.ROB_WIDTH(ROB_WIDTH)) dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .rdy_in              (rdy_in),
    .clr_in              (clr_in),
    .issue_ready         (issue_ready),
    .issue_rd_id         (issue_rd_id),
    .issue_rob_index     (issue_rob_index),
    .iu_rs1_id           (iu_rs1_id),
    .iu_rs2_id           (iu_rs2_id),
    .rf_to_iu_rs1_busy   (rf_to_iu_rs1_busy),
    .rf_to_iu_rs1_depend (rf_to_iu_rs1_depend),
    .rf_to_iu_val1       (rf_to_iu_val1),
    .rf_to_iu_rs2_busy   (rf_to_iu_rs2_busy),
    .rf_to_iu_rs2_depend (rf_to_iu_rs2_depend),
    .rf_to_iu_val2       (rf_to_iu_val2),
    .rob_to_rf_ready     (rob_to_rf_ready),
    .rob_to_rf_reg_id    (rob_to_rf_reg_id),
    .rob_to_rf_reg_val   (rob_to_rf_reg_val),
    .rob_to_rf_rob_index (rob_to_rf_rob_index)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, observed, expected);
    end
  endtask

  // Advance past the next rising edge; inputs change 1ns after the edge.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    clr_in = 0; issue_ready = 0; issue_rd_id = 0; issue_rob_index = 0;
    rob_to_rf_ready = 0; rob_to_rf_reg_id = 0; rob_to_rf_reg_val = 0;
    rob_to_rf_rob_index = 0;
  endtask

  task automatic do_issue(input logic [4:0] rd, input logic [ROB_WIDTH-1:0] idx);
    issue_ready = 1; issue_rd_id = rd; issue_rob_index = idx;
    tick();
    idle_inputs();
  endtask

  task automatic set_commit(input logic [4:0] rd, input logic [ROB_WIDTH-1:0] idx,
                            input logic [31:0] val);
    rob_to_rf_ready = 1; rob_to_rf_reg_id = rd; rob_to_rf_rob_index = idx;
    rob_to_rf_reg_val = val;
  endtask

  // Read one register through port 1 and compare busy/depend/(optional) value.
  task automatic read1(input string name, input logic [4:0] r, input logic exp_busy,
                       input logic [ROB_WIDTH-1:0] exp_dep, input logic chk_val,
                       input logic [31:0] exp_val);
    iu_rs1_id = r;
    #1;
    check({name, "_busy"}, {31'd0, rf_to_iu_rs1_busy}, {31'd0, exp_busy});
    check({name, "_dep"}, {28'd0, rf_to_iu_rs1_depend}, {28'd0, exp_dep});
    if (chk_val) check({name, "_val"}, rf_to_iu_val1, exp_val);
  endtask

  initial begin
    rst_in = 1; rdy_in = 1; iu_rs1_id = 0; iu_rs2_id = 0;
    idle_inputs();
    #23;
    rst_in = 0;
    tick();

    // Reset state and x0 handling
    read1("rst_x5", 5'd5, 0, 0, 1, 32'h0);
    set_commit(5'd0, 4'd1, 32'hDEADBEEF);
    tick();
    idle_inputs();
    read1("x0_after_write", 5'd0, 0, 0, 1, 32'h0);

    // Rename then commit with bypass
    do_issue(5'd3, 4'd2);
    read1("x3_pending", 5'd3, 1, 4'd2, 0, 32'h0);
    set_commit(5'd3, 4'd2, 32'h55);
    read1("x3_bypass", 5'd3, 0, 0, 1, 32'h55);
    tick();
    idle_inputs();
    read1("x3_committed", 5'd3, 0, 0, 1, 32'h55);

    // Stale commit from an older writer must not release the younger rename
    do_issue(5'd7, 4'd2);
    do_issue(5'd7, 4'd5);
    set_commit(5'd7, 4'd2, 32'h9);
    iu_rs2_id = 5'd7;
    #1;
    check("x7_nobypass_busy", {31'd0, rf_to_iu_rs2_busy}, 32'd1);
    check("x7_nobypass_dep", {28'd0, rf_to_iu_rs2_depend}, 32'd5);
    tick();
    idle_inputs();
    check("x7_still_busy", {31'd0, rf_to_iu_rs2_busy}, 32'd1);
    check("x7_still_dep", {28'd0, rf_to_iu_rs2_depend}, 32'd5);

    // Same-cycle commit (old tag) and re-issue of the same rd
    do_issue(5'd4, 4'd3);
    set_commit(5'd4, 4'd3, 32'h44);
    issue_ready = 1; issue_rd_id = 5'd4; issue_rob_index = 4'd6;
    tick();
    idle_inputs();
    read1("x4_reissued", 5'd4, 1, 4'd6, 0, 32'h0);

    // Flush with concurrent commit and issue
    do_issue(5'd1, 4'd1);
    do_issue(5'd2, 4'd8);
    do_issue(5'd9, 4'd7);
    read1("x9_pending", 5'd9, 1, 4'd7, 0, 32'h0);
    clr_in = 1;
    set_commit(5'd9, 4'd7, 32'h77);
    issue_ready = 1; issue_rd_id = 5'd1; issue_rob_index = 4'd4;
    tick();
    idle_inputs();
    read1("flush_x1", 5'd1, 0, 0, 1, 32'h0);
    read1("flush_x2", 5'd2, 0, 0, 1, 32'h0);
    read1("flush_x9", 5'd9, 0, 0, 1, 32'h77);
    read1("flush_x4", 5'd4, 0, 0, 1, 32'h44);
    read1("flush_x7", 5'd7, 0, 0, 1, 32'h9);

    // Global enable low: nothing changes
    rdy_in = 0;
    issue_ready = 1; issue_rd_id = 5'd10; issue_rob_index = 4'd3;
    set_commit(5'd3, 4'd0, 32'h99);
    tick();
    tick();
    idle_inputs();
    rdy_in = 1;
    read1("hold_x10", 5'd10, 0, 0, 1, 32'h0);
    read1("hold_x3", 5'd3, 0, 0, 1, 32'h55);

    // Asynchronous reset mid-cycle
    do_issue(5'd12, 4'd9);
    iu_rs1_id = 5'd3; iu_rs2_id = 5'd12;
    #2;
    rst_in = 1;
    #1;
    check("arst_val1", rf_to_iu_val1, 32'h0);
    check("arst_busy2", {31'd0, rf_to_iu_rs2_busy}, 32'd0);
    check("arst_dep2", {28'd0, rf_to_iu_rs2_depend}, 32'd0);
    #10;
    rst_in = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
